// File: rtl/mlblock_2dflex_gen2.sv
// rtl/mlblock_2dflex_gen2.sv - multi-lane MAC block with serial config chain, cascade and lane reduction
// Define MLBLOCK_2DFLEX_SAT_EN for saturating accumulator/cascade adds; default build wraps.
module mlblock_2dflex_gen2 #(
    parameter int LANES     = 4,
    parameter int I_W       = 8,
    parameter int W_W       = 8,
    parameter int RES_W     = 32,
    parameter int ACC_LEN_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_en,
    input  logic                   cfg_in,
    output logic                   cfg_out,
    input  logic                   cfg_commit,
    input  logic                   W_en,
    input  logic [LANES*W_W-1:0]   W_in,
    output logic [LANES*W_W-1:0]   W_out,
    input  logic [LANES*I_W-1:0]   I_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*RES_W-1:0] Res_cas_in,
    output logic [LANES*RES_W-1:0] Res_out,
    output logic                   res_valid,
    input  logic                   res_ready
);
    localparam int CFG_BITS = ACC_LEN_W + 3;
    localparam int P = I_W + W_W;
`ifdef MLBLOCK_2DFLEX_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

    state_t                 state;
    logic [CFG_BITS-1:0]    shadow;
    logic [CFG_BITS-1:0]    active;
    logic                   pending;
    logic [ACC_LEN_W-1:0]   cnt;
    logic [LANES*W_W-1:0]   w_reg;
    logic [RES_W-1:0]       acc [LANES];
    logic [LANES*RES_W-1:0] res_reg;

    logic [ACC_LEN_W-1:0]   acc_len;
    logic [ACC_LEN_W-1:0]   eff_len;
    logic                   signed_en;
    logic                   reduce_en;
    logic                   cas_en;
    logic                   beat;
    logic [RES_W-1:0]       acc_next [LANES];
    logic [LANES*RES_W-1:0] res_next;

    assign acc_len   = active[ACC_LEN_W-1:0];
    assign signed_en = active[ACC_LEN_W];
    assign reduce_en = active[ACC_LEN_W+1];
    assign cas_en    = active[ACC_LEN_W+2];
    assign eff_len   = (acc_len == '0) ? ACC_LEN_W'(1) : acc_len;

    assign in_ready  = (state == ACC) || (state == IDLE && !cfg_commit && !pending);
    assign beat      = in_valid && in_ready;
    assign res_valid = (state == DRAIN);
    assign cfg_out   = shadow[0];
    assign W_out     = w_reg;
    assign Res_out   = res_reg;

    function automatic logic [RES_W-1:0] add_res(input logic [RES_W-1:0] a,
                                                 input logic [RES_W-1:0] b,
                                                 input logic sgn);
        logic [RES_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (SAT && sgn && (a[RES_W-1] == b[RES_W-1]) && (s[RES_W-1] != a[RES_W-1]))
            add_res = a[RES_W-1] ? {1'b1, {(RES_W-1){1'b0}}} : {1'b0, {(RES_W-1){1'b1}}};
        else if (SAT && !sgn && s[RES_W])
            add_res = '1;
        else
            add_res = s[RES_W-1:0];
    endfunction

    // Next accumulator values and the result that would be registered on DRAIN entry.
    always_comb begin
        logic [I_W-1:0]        ik;
        logic [W_W-1:0]        wk;
        logic signed [P-1:0]   ps;
        logic [P-1:0]          pu;
        logic [RES_W-1:0]      prod;
        logic [RES_W-1:0]      lane_val [LANES];
        logic [RES_W-1:0]      red;
        ik       = '0;
        wk       = '0;
        ps       = '0;
        pu       = '0;
        prod     = '0;
        red      = '0;
        res_next = '0;
        for (int k = 0; k < LANES; k++) begin
            ik   = I_in[k*I_W +: I_W];
            wk   = w_reg[k*W_W +: W_W];
            ps   = P'($signed(ik)) * P'($signed(wk));
            pu   = P'(ik) * P'(wk);
            prod = signed_en ? RES_W'(ps) : RES_W'(pu);
            acc_next[k] = (state == IDLE) ? prod : add_res(acc[k], prod, signed_en);
            lane_val[k] = cas_en ? add_res(acc_next[k], Res_cas_in[k*RES_W +: RES_W], signed_en)
                                 : acc_next[k];
        end
        red = lane_val[0];
        for (int k = 1; k < LANES; k++)
            red = add_res(red, lane_val[k], signed_en);
        if (reduce_en)
            res_next[RES_W-1:0] = red;
        else
            for (int k = 0; k < LANES; k++)
                res_next[k*RES_W +: RES_W] = lane_val[k];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shadow  <= '0;
            active  <= {3'b001, ACC_LEN_W'(1)};
            pending <= 1'b0;
            cnt     <= '0;
            w_reg   <= '0;
            res_reg <= '0;
            for (int k = 0; k < LANES; k++)
                acc[k] <= '0;
        end else begin
            if (cfg_en)
                shadow <= {cfg_in, shadow[CFG_BITS-1:1]};
            if (W_en)
                w_reg <= W_in;
            case (state)
                IDLE: begin
                    if (cfg_commit || pending) begin
                        active  <= shadow;
                        pending <= 1'b0;
                    end else if (beat) begin
                        acc <= acc_next;
                        cnt <= ACC_LEN_W'(1);
                        if (eff_len == ACC_LEN_W'(1)) begin
                            state   <= DRAIN;
                            res_reg <= res_next;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (cfg_commit)
                        pending <= 1'b1;
                    if (beat) begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                        if (cnt + 1'b1 == eff_len) begin
                            state   <= DRAIN;
                            res_reg <= res_next;
                        end
                    end
                end
                DRAIN: begin
                    if (cfg_commit)
                        pending <= 1'b1;
                    if (res_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mlblock_2dflex_gen2.sv
// tb/tb_mlblock_2dflex_gen2.sv - directed-vector bench for mlblock_2dflex_gen2
module tb_mlblock_2dflex_gen2;
    localparam int LANES = 4, I_W = 8, W_W = 8, RES_W = 16, ACC_LEN_W = 8;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   cfg_en = 1'b0, cfg_in = 1'b0, cfg_commit = 1'b0;
    logic                   cfg_out;
    logic                   W_en = 1'b0;
    logic [LANES*W_W-1:0]   W_in = '0;
    logic [LANES*W_W-1:0]   W_out;
    logic [LANES*I_W-1:0]   I_in = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [LANES*RES_W-1:0] Res_cas_in = '0;
    logic [LANES*RES_W-1:0] Res_out;
    logic                   res_valid;
    logic                   res_ready = 1'b0;

    int vectors = 0;
    int errors  = 0;

    mlblock_2dflex_gen2 #(.LANES(LANES), .I_W(I_W), .W_W(W_W), .RES_W(RES_W),
                          .ACC_LEN_W(ACC_LEN_W)) dut (
        .clk(clk), .reset(reset), .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_out(cfg_out),
        .cfg_commit(cfg_commit), .W_en(W_en), .W_in(W_in), .W_out(W_out), .I_in(I_in),
        .in_valid(in_valid), .in_ready(in_ready), .Res_cas_in(Res_cas_in), .Res_out(Res_out),
        .res_valid(res_valid), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] r4(input logic [15:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [31:0] b4(input logic [7:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic shift_cfg(input logic [7:0] len, input logic sg, input logic red, input logic cas);
        logic [10:0] v;
        v = {cas, red, sg, len};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk); cfg_en = 1'b1; cfg_in = v[i];
        end
        @(negedge clk); cfg_en = 1'b0; cfg_in = 1'b0;
    endtask

    task automatic commit_idle();
        @(negedge clk); cfg_commit = 1'b1;
        @(negedge clk); cfg_commit = 1'b0;
    endtask

    task automatic set_w(input logic [31:0] w);
        @(negedge clk); W_en = 1'b1; W_in = w;
        @(negedge clk); W_en = 1'b0;
    endtask

    task automatic beat(input logic [31:0] i);
        @(negedge clk); I_in = i; in_valid = 1'b1;
    endtask

    task automatic drain();
        @(negedge clk); res_ready = 1'b1;
        @(negedge clk); res_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        vectors++; if (cfg_out !== 1'b0) begin errors++; $display("FAIL reset_cfg_out got %b want 0", cfg_out); end
        vectors++; if (Res_out !== 64'h0) begin errors++; $display("FAIL reset_res_out got %h want 0", Res_out); end
        vectors++; if (W_out !== 32'h0) begin errors++; $display("FAIL reset_w_out got %h want 0", W_out); end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        shift_cfg(8'd3, 1'b1, 1'b0, 1'b0);
        vectors++; if (cfg_out !== 1'b1) begin errors++; $display("FAIL cfg_out_lsb got %b want 1", cfg_out); end
        commit_idle();
        set_w(b4(2, 2, 2, 2));
        vectors++; if (W_out !== b4(2, 2, 2, 2)) begin errors++; $display("FAIL w_out got %h want %h", W_out, b4(2, 2, 2, 2)); end
        beat(b4(1, 2, 3, 4)); beat(b4(1, 2, 3, 4)); beat(b4(1, 2, 3, 4));
        vectors++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", res_valid); end
        @(negedge clk); in_valid = 1'b0;
        vectors++; if (res_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got %b want 1", res_valid); end
        vectors++; if (Res_out !== r4(6, 12, 18, 24)) begin errors++; $display("FAIL basic_res got %h want %h", Res_out, r4(6, 12, 18, 24)); end
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_in_ready got %b want 0", in_ready); end
        drain();
        vectors++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_idle_valid got %b want 0", res_valid); end
        vectors++; if (Res_out !== r4(6, 12, 18, 24)) begin errors++; $display("FAIL basic_hold got %h want %h", Res_out, r4(6, 12, 18, 24)); end
    endtask

    task automatic test_reduce_cascade();
        shift_cfg(8'd3, 1'b1, 1'b1, 1'b1);
        commit_idle();
        Res_cas_in = r4(10, 10, 10, 10);
        beat(b4(1, 2, 3, 4)); beat(b4(1, 2, 3, 4)); beat(b4(1, 2, 3, 4));
        @(negedge clk); in_valid = 1'b0;
        vectors++; if (Res_out !== r4(100, 0, 0, 0)) begin errors++; $display("FAIL reduce_cas got %h want %h", Res_out, r4(100, 0, 0, 0)); end
        drain();
        Res_cas_in = '0;
    endtask

    task automatic test_saturation();
        logic [15:0] exp_lane;
`ifdef MLBLOCK_2DFLEX_SAT_EN
        exp_lane = 16'h7FFF;
`else
        exp_lane = 16'h8000;
`endif
        shift_cfg(8'd2, 1'b1, 1'b0, 1'b0);
        commit_idle();
        set_w(b4(8'h80, 8'h80, 8'h80, 8'h80));
        beat(b4(8'h80, 8'h80, 8'h80, 8'h80)); beat(b4(8'h80, 8'h80, 8'h80, 8'h80));
        @(negedge clk); in_valid = 1'b0;
        vectors++; if (Res_out !== r4(exp_lane, exp_lane, exp_lane, exp_lane)) begin errors++; $display("FAIL sat_wrap got %h want lanes %h", Res_out, exp_lane); end
        drain();
    endtask

    task automatic test_acc_len0_unsigned();
        shift_cfg(8'd0, 1'b0, 1'b0, 1'b0);
        commit_idle();
        set_w(b4(2, 2, 2, 2));
        beat(b4(8'hFF, 8'hFF, 8'hFF, 8'hFF));
        @(negedge clk); in_valid = 1'b0;
        vectors++; if (res_valid !== 1'b1) begin errors++; $display("FAIL len0_valid got %b want 1", res_valid); end
        vectors++; if (Res_out !== r4(16'h01FE, 16'h01FE, 16'h01FE, 16'h01FE)) begin errors++; $display("FAIL len0_unsigned got %h want lanes 01fe", Res_out); end
        drain();
    endtask

    task automatic test_pending_commit();
        shift_cfg(8'd2, 1'b1, 1'b0, 1'b0);
        commit_idle();
        set_w(b4(3, 3, 3, 3));
        beat(b4(5, 6, 7, 8));
        @(negedge clk); in_valid = 1'b0; W_en = 1'b1; W_in = b4(1, 1, 1, 1);
        @(negedge clk); W_en = 1'b0;
        shift_cfg(8'd1, 1'b1, 1'b0, 1'b0);
        @(negedge clk); cfg_commit = 1'b1;
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL acc_in_ready got %b want 1", in_ready); end
        @(negedge clk); cfg_commit = 1'b0;
        beat(b4(1, 1, 1, 1));
        @(negedge clk); in_valid = 1'b0;
        vectors++; if (Res_out !== r4(16, 19, 22, 25)) begin errors++; $display("FAIL weight_update got %h want %h", Res_out, r4(16, 19, 22, 25)); end
        drain();
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pending_in_ready got %b want 0", in_ready); end
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_commit_in_ready got %b want 1", in_ready); end
        beat(b4(2, 3, 4, 5));
        @(negedge clk); in_valid = 1'b0;
        vectors++; if (res_valid !== 1'b1) begin errors++; $display("FAIL new_len_valid got %b want 1", res_valid); end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; I_in = b4(9, 9, 9, 9);
            vectors++; if (res_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_handshake cycle %0d got valid=%b ready=%b want 1/0", c, res_valid, in_ready); end
            vectors++; if (Res_out !== r4(2, 3, 4, 5)) begin errors++; $display("FAIL bp_stable cycle %0d got %h want %h", c, Res_out, r4(2, 3, 4, 5)); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid_acc();
        shift_cfg(8'd3, 1'b1, 1'b0, 1'b0);
        commit_idle();
        beat(b4(1, 1, 1, 1));
        @(negedge clk); in_valid = 1'b0;
        reset = 1'b0;
        #1;
        vectors++; if (Res_out !== 64'h0 || W_out !== 32'h0) begin errors++; $display("FAIL rst_async_data got res=%h w=%h want 0", Res_out, W_out); end
        vectors++; if (res_valid !== 1'b0 || in_ready !== 1'b1 || cfg_out !== 1'b0) begin errors++; $display("FAIL rst_async_ctrl got v=%b r=%b c=%b want 0/1/0", res_valid, in_ready, cfg_out); end
        @(negedge clk); reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_no_valid cycle %0d got %b want 0", c, res_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reduce_cascade();
        test_saturation();
        test_acc_len0_unsigned();
        test_pending_commit();
        test_backpressure();
        test_reset_mid_acc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
